fft_frame_sequencer: RTL and testbench

Sequences one R2FFT frame per audio capture: it takes 12-bit unsigned ADC samples, converts them to signed FFT input, and streams FFT_LENGTH samples into the core. It then starts the transform, waits for `done`, scans the lower half-spectrum over the DMA bus, and reports the peak-magnitude bin. The block sits between the ADC response register and `R2FFT`, and replaces manual control of `run`, `input_stream_active` and `dmaact`.

---
 rtl/fft_frame_sequencer_pkg.sv | 16 +
 rtl/fft_frame_sequencer_peak_tracker.sv | 39 +++
 rtl/fft_frame_sequencer.sv | 142 ++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and constants for the R2FFT frame sequencer.
package fft_seq_pkg;

    localparam int ADC_W        = 12;
    localparam int ADC_MIDSCALE = 2048;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_START,
        S_WAIT,
        S_SCAN,
        S_REPORT
    } seq_state_t;

endpackage

// File: rtl/fft_frame_sequencer_peak_tracker.sv
// Running |re|+|im| maximum over the returned DMA words; the lowest bin wins ties.
module peak_tracker #(
    parameter int FFT_DW = 16,
    parameter int BIN_W  = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic [BIN_W-1:0]         bin,
    input  logic signed [FFT_DW-1:0] re,
    input  logic signed [FFT_DW-1:0] im,
    output logic [BIN_W-1:0]         max_bin,
    output logic [FFT_DW:0]          max_mag
);

    // The most negative code maps onto 2^(FFT_DW-1), which still fits unsigned.
    function automatic logic [FFT_DW-1:0] abs_val(input logic signed [FFT_DW-1:0] v);
        return v[FFT_DW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    logic [FFT_DW:0] mag;

    assign mag = {1'b0, abs_val(re)} + {1'b0, abs_val(im)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_bin <= BIN_W'(1);
            max_mag <= '0;
        end else if (clear) begin
            max_bin <= BIN_W'(1);
            max_mag <= '0;
        end else if (load && (mag > max_mag)) begin
            max_bin <= bin;
            max_mag <= mag;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Captures one frame of ADC samples into R2FFT, runs it, and reports the
// peak-magnitude bin of the lower half-spectrum read back over the DMA port.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int FFT_LENGTH = 1024,
    parameter int FFT_DW     = 16,
    parameter int DMA_LAT    = 2,
    parameter int FFT_N      = $clog2(FFT_LENGTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic [ADC_W-1:0]         sample_data,
    output logic                     input_stream_active,
    output logic signed [FFT_DW-1:0] input_real,
    output logic                     run,
    input  logic                     done,
    input  logic signed [7:0]        bfpexp,
    output logic                     dmaact,
    output logic [FFT_N-1:0]         dmaa,
    input  logic signed [FFT_DW-1:0] dmadr_real,
    input  logic signed [FFT_DW-1:0] dmadr_imag,
    output logic                     peak_valid,
    output logic [FFT_N-2:0]         peak_bin,
    output logic [FFT_DW:0]          peak_mag,
    output logic signed [7:0]        peak_exp,
    output logic [7:0]               drop_cnt,
    output logic                     busy
);

    localparam int HALF      = FFT_LENGTH / 2;
    localparam int SCAN_LAST = HALF - 1 + DMA_LAT;
    localparam int SCW       = $clog2(SCAN_LAST + 1);

    seq_state_t        state, state_n;
    logic [FFT_N-1:0]  sample_cnt;
    logic [SCW-1:0]    scan_cnt;
    logic signed [7:0] exp_q;
    logic [DMA_LAT-1:0] vld_p;
    logic [FFT_N-2:0]  bin_p [DMA_LAT];
    logic [FFT_N-2:0]  max_bin;
    logic [FFT_DW:0]   max_mag;
    logic              accept, last_sample, scan_start, addr_more;

    // Offset-binary to two's complement, then left-justified in the FFT word.
    function automatic logic signed [FFT_DW-1:0] to_signed(input logic [ADC_W-1:0] code);
        logic signed [ADC_W-1:0] centered;
        centered = $signed(code - ADC_W'(ADC_MIDSCALE));
        return {centered, {(FFT_DW-ADC_W){1'b0}}};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    always_comb begin
        state_n     = state;
        accept      = (state == S_FILL) && sample_valid;
        last_sample = accept && (sample_cnt == FFT_N'(FFT_LENGTH - 1));
        scan_start  = (state == S_WAIT) && done;
        addr_more   = (state == S_SCAN) && dmaact && (dmaa < FFT_N'(HALF - 1));
        case (state)
            S_IDLE:   if (enable) state_n = S_FILL;
            S_FILL:   if (last_sample) state_n = S_START;
            S_START:  state_n = S_WAIT;
            S_WAIT:   if (done) state_n = S_SCAN;
            S_SCAN:   if (scan_cnt == SCW'(SCAN_LAST)) state_n = S_REPORT;
            S_REPORT: state_n = enable ? S_FILL : S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            busy                <= 1'b0;
            run                 <= 1'b0;
            input_stream_active <= 1'b0;
            input_real          <= '0;
            drop_cnt            <= '0;
            sample_cnt          <= '0;
            dmaact              <= 1'b0;
            dmaa                <= '0;
            scan_cnt            <= '0;
            exp_q               <= '0;
            vld_p               <= '0;
            peak_valid          <= 1'b0;
            peak_bin            <= '0;
            peak_mag            <= '0;
            peak_exp            <= '0;
        end else begin
            state               <= state_n;
            busy                <= (state_n != S_IDLE);
            run                 <= (state_n == S_START);
            input_stream_active <= accept;
            if (accept) input_real <= to_signed(sample_data);
            if (sample_valid && (state != S_FILL)) drop_cnt <= sat_inc(drop_cnt);
            // Power-of-2 length lets the counter wrap to 0 on the last sample.
            if (state != S_FILL) sample_cnt <= '0;
            else if (accept)     sample_cnt <= sample_cnt + FFT_N'(1);

            dmaact   <= scan_start || addr_more;
            dmaa     <= scan_start ? FFT_N'(1) : (addr_more ? dmaa + FFT_N'(1) : '0);
            scan_cnt <= (state == S_SCAN) ? scan_cnt + SCW'(1) : '0;
            if (scan_start) exp_q <= bfpexp;

            vld_p[0] <= dmaact;
            for (int i = 1; i < DMA_LAT; i++) vld_p[i] <= vld_p[i-1];

            peak_valid <= (state_n == S_REPORT);
            if (state_n == S_REPORT) begin
                peak_bin <= max_bin;
                peak_mag <= max_mag;
                peak_exp <= exp_q;
            end
        end
    end

    // Bin address rides alongside the DMA read latency.
    always_ff @(posedge clk) begin
        bin_p[0] <= dmaa[FFT_N-2:0];
        for (int i = 1; i < DMA_LAT; i++) bin_p[i] <= bin_p[i-1];
    end

    peak_tracker #(
        .FFT_DW (FFT_DW),
        .BIN_W  (FFT_N - 1)
    ) u_peak (
        .clk     (clk),
        .rst     (rst),
        .clear   (scan_start),
        .load    (vld_p[DMA_LAT-1]),
        .bin     (bin_p[DMA_LAT-1]),
        .re      (dmadr_real),
        .im      (dmadr_imag),
        .max_bin (max_bin),
        .max_mag (max_mag)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a 16-point frame and a 2-cycle DMA model.
module tb_fft_frame_sequencer;

    localparam int L   = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int N   = 4;

    logic               MAX10_CLK1_50;
    logic               rst, enable, sample_valid, done;
    logic [11:0]        sample_data;
    logic signed [7:0]  bfpexp;
    logic               input_stream_active, run, dmaact, peak_valid, busy;
    logic signed [DW-1:0] input_real, dmadr_real, dmadr_imag;
    logic [N-1:0]       dmaa;
    logic [N-2:0]       peak_bin;
    logic [DW:0]        peak_mag;
    logic signed [7:0]  peak_exp;
    logic [7:0]         drop_cnt;

    fft_frame_sequencer #(.FFT_LENGTH(L), .FFT_DW(DW), .DMA_LAT(LAT)) dut (
        .clk(MAX10_CLK1_50), .rst(rst), .enable(enable),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .input_stream_active(input_stream_active), .input_real(input_real),
        .run(run), .done(done), .bfpexp(bfpexp),
        .dmaact(dmaact), .dmaa(dmaa), .dmadr_real(dmadr_real), .dmadr_imag(dmadr_imag),
        .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_mag(peak_mag),
        .peak_exp(peak_exp), .drop_cnt(drop_cnt), .busy(busy)
    );

    initial MAX10_CLK1_50 = 1'b0;
    always #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;

    // DMA memory model with fixed read latency
    logic signed [DW-1:0] mem_re [L];
    logic signed [DW-1:0] mem_im [L];
    logic [N-1:0]         apipe [LAT];

    always @(posedge MAX10_CLK1_50) begin
        apipe[0] <= dmaa;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign dmadr_real = mem_re[apipe[LAT-1]];
    assign dmadr_imag = mem_im[apipe[LAT-1]];

    int isa_cnt = 0, run_cnt = 0, dma_cnt = 0;
    always @(negedge MAX10_CLK1_50) begin
        if (input_stream_active) isa_cnt++;
        if (run) run_cnt++;
        if (dmaact) dma_cnt++;
    end

    int checks = 0, failures = 0;

    typedef struct {
        logic [11:0]        code;
        logic signed [15:0] exp_real;
    } smp_t;

    typedef struct {
        int                pat;
        int                mode;
        logic signed [7:0] e;
        int                drop_at;
        int                wait_drops;
        bit                rep_drop;
        int                ebin;
        int                emag;
    } frame_t;

    smp_t   smp [16];
    frame_t frames [7];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge MAX10_CLK1_50);
        #1;
    endtask

    task automatic set_mode(input int mode);
        for (int k = 0; k < L; k++) begin
            mem_re[k] = '0;
            mem_im[k] = '0;
            case (mode)
                0: begin mem_re[k] = 16'(100 * k); mem_im[k] = -16'sd50; end
                1: mem_im[k] = 16'(10 * k);
                2: mem_re[k] = 16'(k);
                4: begin mem_re[k] = 16'(-k); mem_im[k] = 16'(k); end
                5: mem_re[k] = 16'(k);
                default: ;
            endcase
        end
        if (mode == 1) begin
            mem_re[3] = 16'sd300;  mem_im[3] = -16'sd200;
            mem_re[5] = -16'sd250; mem_im[5] = 16'sd250;
        end
        if (mode == 2) begin
            mem_re[2] = -16'sd32768; mem_im[2] = 16'sd0;
            mem_re[6] = 16'sd32767;
        end
        if (mode == 4) begin
            mem_re[0] = 16'sd32767; mem_im[0] = 16'sd32767;
            for (int k = 8; k < L; k++) begin mem_re[k] = -16'sd32768; mem_im[k] = -16'sd32768; end
        end
        if (mode == 5) begin
            mem_re[4] = -16'sd32768; mem_im[4] = -16'sd32768;
            mem_re[6] = 16'sd32767;  mem_im[6] = 16'sd32767;
        end
    endtask

    // Feeds one full frame; returns in the START cycle.
    task automatic fill_frame(input int pat, input int drop_at, input int idx);
        logic [11:0]        c;
        logic signed [15:0] x;
        for (int i = 0; i < L; i++) begin
            c = (pat == 0) ? 12'd2048 : smp[i].code;
            x = (pat == 0) ? 16'sd0 : smp[i].exp_real;
            sample_valid = 1'b1;
            sample_data  = c;
            tick();
            sample_valid = 1'b0;
            check($sformatf("f%0d_isa_%0d", idx, i), input_stream_active, 1);
            check($sformatf("f%0d_real_%0d", idx, i), input_real, x);
            check($sformatf("f%0d_run_%0d", idx, i), run, (i == L - 1) ? 1 : 0);
            if (i == drop_at) enable = 1'b0;
            if (i != L - 1) tick();
        end
    endtask

    task automatic do_frame(input frame_t f, input int idx);
        int isa0, run0, dma0, drop0, k;
        if (!busy) begin
            enable = 1'b1;
            tick();
        end
        isa0 = isa_cnt;
        run0 = run_cnt;
        fill_frame(f.pat, f.drop_at, idx);
        tick();
        check($sformatf("f%0d_strobes", idx), isa_cnt - isa0, L);
        check($sformatf("f%0d_runs", idx), run_cnt - run0, 1);
        check($sformatf("f%0d_run_low", idx), run, 0);
        drop0 = drop_cnt;
        repeat (f.wait_drops) begin
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
            tick();
        end
        check($sformatf("f%0d_wait_drops", idx), drop_cnt - drop0, f.wait_drops);
        check($sformatf("f%0d_wait_busy", idx), busy, 1);
        set_mode(f.mode);
        bfpexp = f.e;
        done   = 1'b1;
        dma0   = dma_cnt;
        tick();
        done   = 1'b0;
        bfpexp = 8'sd99;
        check($sformatf("f%0d_dma_first", idx), {dmaact, dmaa}, {1'b1, 4'd1});
        k = 0;
        while (!peak_valid && k < 40) begin
            tick();
            k++;
        end
        check($sformatf("f%0d_scan_latency", idx), k, 10);
        check($sformatf("f%0d_dma_cycles", idx), dma_cnt - dma0, L / 2 - 1);
        check($sformatf("f%0d_peak_bin", idx), peak_bin, f.ebin);
        check($sformatf("f%0d_peak_mag", idx), peak_mag, f.emag);
        check($sformatf("f%0d_peak_exp", idx), peak_exp, f.e);
        drop0 = drop_cnt;
        if (f.rep_drop) sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check($sformatf("f%0d_pv_pulse", idx), peak_valid, 0);
        check($sformatf("f%0d_bin_hold", idx), peak_bin, f.ebin);
        check($sformatf("f%0d_rep_drop", idx), drop_cnt - drop0, f.rep_drop ? 1 : 0);
        check($sformatf("f%0d_after_busy", idx), busy, enable);
        check($sformatf("f%0d_after_isa", idx), input_stream_active, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        smp = '{
            '{12'd0,    -16'sd32768}, '{12'd4095,  16'sd32752},
            '{12'd2048,  16'sd0},     '{12'd2049,  16'sd16},
            '{12'd2047, -16'sd16},    '{12'd1024, -16'sd16384},
            '{12'd3072,  16'sd16384}, '{12'd1,    -16'sd32752},
            '{12'd4094,  16'sd32736}, '{12'd100,  -16'sd31168},
            '{12'd2000, -16'sd768},   '{12'd3000,  16'sd15232},
            '{12'd512,  -16'sd24576}, '{12'd3584,  16'sd24576},
            '{12'd2056,  16'sd128},   '{12'd2040, -16'sd128}
        };
        frames = '{
            '{0, 0,  8'sd3,    -1, 5, 1'b1, 7, 750},
            '{1, 1, -8'sd2,    -1, 0, 1'b0, 3, 500},
            '{0, 2,  8'sd0,     7, 0, 1'b0, 2, 32768},
            '{0, 3,  8'sd127,  -1, 0, 1'b1, 1, 0},
            '{1, 4, -8'sd128,  -1, 0, 1'b0, 7, 14},
            '{0, 5,  8'sd5,    15, 0, 1'b0, 4, 65536},
            '{1, 0,  8'sd3,    -1, 0, 1'b0, 7, 750}
        };

        rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;
        done = 1'b0; bfpexp = '0;
        set_mode(3);
        tick();
        tick();
        check("reset_outputs", {input_stream_active, input_real, run, dmaact, dmaa, peak_valid,
                                peak_bin, peak_mag, peak_exp, drop_cnt, busy}, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) do_frame(frames[i], i);

        check("idle_after_enable_drop", busy, 0);
        enable = 1'b0;
        repeat (300) begin
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
        end
        check("drop_saturate", drop_cnt, 255);
        check("idle_no_strobe", input_stream_active, 0);

        enable = 1'b1;
        tick();
        fill_frame(0, -1, 9);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        check("pre_reset_dmaact", dmaact, 1);
        rst = 1'b1;
        #1;
        check("midscan_reset_outputs", {input_stream_active, input_real, run, dmaact, dmaa, peak_valid,
                                        peak_bin, peak_mag, peak_exp, drop_cnt, busy}, 0);
        tick();
        rst = 1'b0;
        check("post_reset_busy", busy, 0);
        do_frame(frames[6], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
